// File: rtl/pwm_robot_pkg.sv
// Shared types and constants for the robot PWM consumer block.
// Duty fields are packed one byte per channel in the 32-bit PWM register word.
package pwm_robot_pkg;

  localparam int unsigned CNT_W = 8;

  // Period counter runs 0..254 so that duty 255 is a continuous high.
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd254;

  typedef logic [7:0] duty_t;

  function automatic duty_t duty_field(input logic [31:0] word, input int unsigned ch);
    return word[8*ch +: 8];
  endfunction

endpackage

// File: rtl/pwm_gen_robot_tick.sv
// Clock prescaler for the robot PWM: one tick every PRESCALE enabled cycles.
// The count is held at zero while disabled so each enable starts a full step.
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_last;

  assign w_last = (r_pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pre_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  assign o_tick = w_last && i_en;

endmodule

// File: rtl/pwm_gen_robot.sv
// Four-channel PWM generator fed by the IO block's 32-bit PWM register word.
// Define PWM_SHADOW_EN to latch duties only at period boundaries (glitch-free).
module pwm_gen_robot
  import pwm_robot_pkg::*;
#(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned NUM_CH   = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [31:0]       pwm_word,
  input  logic              en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  logic             w_tick;
  logic             w_wrap;
  logic             w_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en_d;
  logic             r_period_start;
  duty_t            w_duty [NUM_CH];

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .nrst  (nrst),
    .i_en  (en),
    .o_tick(w_tick)
  );

  assign w_wrap = w_tick && (r_cnt == CNT_MAX);
  assign w_rise = en && !r_en_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (!en || w_wrap) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_en_d         <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_en_d         <= en;
      r_period_start <= w_wrap || w_rise;
    end
  end

  assign period_start = r_period_start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic r_out;

`ifdef PWM_SHADOW_EN
    duty_t r_shadow;

    // Tracks the register continuously while disabled so enable starts on fresh data.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_shadow <= '0;
      end else if (!en || w_wrap) begin
        r_shadow <= duty_field(pwm_word, g);
      end
    end

    assign w_duty[g] = r_shadow;
`else
    assign w_duty[g] = duty_field(pwm_word, g);
`endif

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_out <= 1'b0;
      end else begin
        r_out <= en && (r_cnt < w_duty[g]);
      end
    end

    assign pwm_out[g] = r_out;
  end

endmodule
